digdug_vout: RTL and testbench

DIGDUG_VOUT -- requirements
Module: digdug_vout

---
 rtl/digdug_pkg.sv | 33 +++
 rtl/digdug_vout_if.sv | 26 ++
 rtl/digdug_dly.sv | 38 +++
 rtl/digdug_vout.sv | 126 ++++++++++++
 tb/tb_digdug_vout.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/digdug_pkg.sv
// Shared line/frame geometry, timing bundle type and colour expansion helpers
// for the Dig Dug video output stage.
package digdug_pkg;

    localparam logic [8:0] H_FIRST   = 9'd128;
    localparam logic [8:0] H_LAST    = 9'd511;
    localparam logic [8:0] H_ACTIVE  = 9'd224;
    localparam logic [8:0] V_TOTAL   = 9'd264;
    localparam logic [8:0] V_LAST    = V_TOTAL - 9'd1;
    localparam logic [8:0] V_BLANK   = 9'd224;
    localparam logic [8:0] HS_WIDTH  = 9'd32;
    localparam logic [8:0] VS_WIDTH  = 9'd8;
    localparam logic [2:0] DIV_PCE_M1 = 3'd6;

    typedef struct packed {
        logic hblank;
        logic vblank;
        logic hsync;
        logic vsync;
    } timing_t;

    // Blank asserted, sync idle: what the delay line holds out of reset.
    localparam timing_t TIMING_IDLE = '{hblank: 1'b1, vblank: 1'b1, hsync: 1'b0, vsync: 1'b0};

    function automatic logic [7:0] expand3(input logic [2:0] c);
        return {c, c, c[2:1]};
    endfunction

    function automatic logic [7:0] expand2(input logic [1:0] c);
        return {c, c, c, c};
    endfunction

endpackage

// File: rtl/digdug_vout_if.sv
// Video bundle between the video stage (palette byte in) and the display side
// (position, timing and expanded colour out).
interface digdug_vout_if;
    logic [7:0] POUT;
    logic       PCE;
    logic [8:0] POSH;
    logic [8:0] POSV;
    logic       HBLANK;
    logic       VBLANK;
    logic       HSYNC;
    logic       VSYNC;
    logic       VBIRQ;
    logic [7:0] RED;
    logic [7:0] GRN;
    logic [7:0] BLU;

    modport master (
        input  POUT,
        output PCE, POSH, POSV, HBLANK, VBLANK, HSYNC, VSYNC, VBIRQ, RED, GRN, BLU
    );

    modport slave (
        output POUT,
        input  PCE, POSH, POSV, HBLANK, VBLANK, HSYNC, VSYNC, VBIRQ, RED, GRN, BLU
    );
endinterface

// File: rtl/digdug_dly.sv
// Clock-enable gated shift register; every stage loads INIT while rst is high.
module digdug_dly #(
    parameter int               WIDTH = 4,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage_r [DEPTH];

            // Shift one stage per enable, oldest sample at the far end
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        stage_r[i] <= INIT;
                    end
                end else if (ce) begin
                    stage_r[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign q = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/digdug_vout.sv
// Video timing generator and colour output stage: pixel enable, beam position,
// delayed sync/blank aligned with the registered, blanked RGB expansion.
module digdug_vout
    import digdug_pkg::*;
#(
    parameter int PIX_LAT  = 2,
    parameter int HS_START = 144,
    parameter int VS_START = 232
) (
    input  logic          CLK48M,
    input  logic          RESET,
    digdug_vout_if.master vid
);

    localparam logic [8:0] HS_FIRST = 9'(HS_START);
    localparam logic [8:0] VS_FIRST = 9'(VS_START);

    logic [2:0] div_r;
    logic       pce_r;
    logic [8:0] posh_r;
    logic [8:0] posv_r;
    logic [8:0] posh_nxt_s;
    logic [8:0] posv_nxt_s;
    logic       vbirq_r;
    timing_t    raw_s;
    timing_t    dly_s;
    timing_t    tim_r;
    logic [7:0] red_r;
    logic [7:0] grn_r;
    logic [7:0] blu_r;

    // Beam position one pixel ahead, with line and frame wrap
    always_comb begin
        posh_nxt_s = posh_r + 9'd1;
        posv_nxt_s = posv_r;
        if (posh_r == H_LAST) begin
            posh_nxt_s = H_FIRST;
            if (posv_r == V_LAST) begin
                posv_nxt_s = 9'd0;
            end else begin
                posv_nxt_s = posv_r + 9'd1;
            end
        end else begin
            posv_nxt_s = posv_r;
        end
    end

    // Undelayed blank/sync decoded from the current beam position
    always_comb begin
        raw_s        = TIMING_IDLE;
        raw_s.hblank = (posh_r < H_ACTIVE);
        raw_s.vblank = (posv_r >= V_BLANK);
        raw_s.hsync  = (posh_r >= HS_FIRST) && (posh_r < HS_FIRST + HS_WIDTH);
        raw_s.vsync  = (posv_r >= VS_FIRST) && (posv_r < VS_FIRST + VS_WIDTH);
    end

    // Divide-by-8 pixel enable; registered so PCE is high while the divider reads 7
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            div_r <= 3'd0;
            pce_r <= 1'b0;
        end else begin
            div_r <= div_r + 3'd1;
            pce_r <= (div_r == DIV_PCE_M1);
        end
    end

    // Beam counters and the vertical-blank interrupt pulse
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            posh_r  <= H_FIRST;
            posv_r  <= 9'd0;
            vbirq_r <= 1'b0;
        end else if (pce_r) begin
            posh_r  <= posh_nxt_s;
            posv_r  <= posv_nxt_s;
            vbirq_r <= (posh_nxt_s == H_FIRST) && (posv_nxt_s == V_BLANK);
        end
    end

    digdug_dly #(
        .WIDTH (4),
        .DEPTH (PIX_LAT),
        .INIT  (TIMING_IDLE)
    ) u_dly (
        .clk (CLK48M),
        .rst (RESET),
        .ce  (pce_r),
        .d   (raw_s),
        .q   (dly_s)
    );

    // Output stage: the blank that gates RGB is the same one entering tim_r
    always_ff @(posedge CLK48M) begin
        if (RESET) begin
            tim_r <= TIMING_IDLE;
            red_r <= 8'd0;
            grn_r <= 8'd0;
            blu_r <= 8'd0;
        end else if (pce_r) begin
            tim_r <= dly_s;
            if (dly_s.hblank || dly_s.vblank) begin
                red_r <= 8'd0;
                grn_r <= 8'd0;
                blu_r <= 8'd0;
            end else begin
                red_r <= expand3(vid.POUT[2:0]);
                grn_r <= expand3(vid.POUT[5:3]);
                blu_r <= expand2(vid.POUT[7:6]);
            end
        end
    end

    assign vid.PCE    = pce_r;
    assign vid.POSH   = posh_r;
    assign vid.POSV   = posv_r;
    assign vid.VBIRQ  = vbirq_r;
    assign vid.HBLANK = tim_r.hblank;
    assign vid.VBLANK = tim_r.vblank;
    assign vid.HSYNC  = tim_r.hsync;
    assign vid.VSYNC  = tim_r.vsync;
    assign vid.RED    = red_r;
    assign vid.GRN    = grn_r;
    assign vid.BLU    = blu_r;

endmodule

// File: tb/tb_digdug_vout.sv
// Self-checking bench for digdug_vout: a position/timing/colour model driven by
// the bench's own cycle count, a colour table, and sync/reset corner sequences.
module tb_digdug_vout;

    localparam int PIX_LAT  = 2;
    localparam int HS_START = 144;
    localparam int VS_START = 4;
    localparam int DLY      = PIX_LAT + 1;

    typedef struct {
        logic [7:0] pout;
        logic [7:0] red;
        logic [7:0] grn;
        logic [7:0] blu;
    } vec_t;

    logic       CLK48M     = 1'b0;
    logic       RESET      = 1'b1;
    int         n_checks   = 0;
    int         n_fail     = 0;
    int         c          = 0;
    bit         started    = 1'b0;
    bit         rand_en    = 1'b1;
    logic [7:0] table_pout = 8'h00;
    logic [7:0] hist [0:8191];

    digdug_vout_if vid ();

    digdug_vout #(
        .PIX_LAT  (PIX_LAT),
        .HS_START (HS_START),
        .VS_START (VS_START)
    ) dut (
        .CLK48M (CLK48M),
        .RESET  (RESET),
        .vid    (vid)
    );

    always #5 CLK48M = ~CLK48M;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h, expected %0h (cycle %0d after reset)", name, act, exp, c);
        end
    endtask

    // Pixel p after reset release: linear raster scan of 384 x 264.
    function automatic int m_posh(input int p);
        return 128 + (p % 384);
    endfunction

    function automatic int m_posv(input int p);
        return (p / 384) % 264;
    endfunction

    // {hblank, vblank, hsync, vsync} seen at the outputs in pixel period p.
    function automatic logic [3:0] m_timing(input int p);
        int q, h, v;
        q = p - DLY;
        if (q < 0) return 4'b1100;
        h = m_posh(q);
        v = m_posv(q);
        return {h < 224, v >= 224, (h >= HS_START) && (h < HS_START + 32),
                (v >= VS_START) && (v < VS_START + 8)};
    endfunction

    // 3-bit level scaled to 0..255 with rounding.
    function automatic int m_scale3(input int level);
        return (level * 510 + 7) / 14;
    endfunction

    // Cycle count since the last reset edge.
    always @(posedge CLK48M) begin
        if (RESET) begin
            c       <= 0;
            started <= 1'b1;
        end else begin
            c <= c + 1;
        end
    end

    // Random palette stream, or the table value when the table phase owns POUT.
    always begin
        @(posedge CLK48M);
        #1;
        vid.POUT = rand_en ? 8'($urandom) : table_pout;
    end

    // Continuous comparison against the raster model.
    always @(negedge CLK48M) begin
        int p, er, eg, eb, h, v;
        logic [3:0] t;
        logic [7:0] x;
        if (started) begin
            p = c / 8;
            h = m_posh(p);
            v = m_posv(p);
            t = m_timing(p);
            check("pce",    32'(vid.PCE),    32'((c % 8) == 7));
            check("posh",   32'(vid.POSH),   32'(h));
            check("posv",   32'(vid.POSV),   32'(v));
            check("hblank", 32'(vid.HBLANK), 32'(t[3]));
            check("vblank", 32'(vid.VBLANK), 32'(t[2]));
            check("hsync",  32'(vid.HSYNC),  32'(t[1]));
            check("vsync",  32'(vid.VSYNC),  32'(t[0]));
            check("vbirq",  32'(vid.VBIRQ),  32'((h == 128) && (v == 224)));
            if (p == 0 || t[3] || t[2]) begin
                er = 0; eg = 0; eb = 0;
            end else begin
                x  = hist[p-1];
                er = m_scale3(int'(x[2:0]));
                eg = m_scale3(int'(x[5:3]));
                eb = int'(x[7:6]) * 85;
            end
            check("red", 32'(vid.RED), 32'(er));
            check("grn", 32'(vid.GRN), 32'(eg));
            check("blu", 32'(vid.BLU), 32'(eb));
            if ((c % 8) == 7) hist[p] = vid.POUT;
        end
    end

    task automatic wait_model_pos(input int h, input int v, input int bound, output int p_at);
        p_at = -1;
        for (int k = 0; k < bound; k++) begin
            @(negedge CLK48M);
            if (m_posh(c / 8) == h && (v < 0 || m_posv(c / 8) == v)) begin
                p_at = c / 8;
                break;
            end
        end
        check("model_pos_reached", 32'(p_at >= 0), 32'd1);
    endtask

    task automatic wait_window(input int lo, input int hi);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 4000 && !hit; k++) begin
            @(negedge CLK48M);
            if (m_posh(c / 8) >= lo && m_posh(c / 8) <= hi) hit = 1'b1;
        end
        check("active_window_reached", 32'(hit), 32'd1);
    endtask

    task automatic wait_sig(input bit vsel, input logic level, input int bound, output int p_at);
        p_at = -100000;
        for (int k = 0; k < bound; k++) begin
            @(negedge CLK48M);
            if ((vsel ? vid.VSYNC : vid.HSYNC) === level) begin
                p_at = c / 8;
                break;
            end
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_posh"},   32'(vid.POSH),   32'd128);
        check({tag, "_posv"},   32'(vid.POSV),   32'd0);
        check({tag, "_pce"},    32'(vid.PCE),    32'd0);
        check({tag, "_vbirq"},  32'(vid.VBIRQ),  32'd0);
        check({tag, "_hblank"}, 32'(vid.HBLANK), 32'd1);
        check({tag, "_vblank"}, 32'(vid.VBLANK), 32'd1);
        check({tag, "_hsync"},  32'(vid.HSYNC),  32'd0);
        check({tag, "_vsync"},  32'(vid.VSYNC),  32'd0);
        check({tag, "_rgb"},    32'({vid.RED, vid.GRN, vid.BLU}), 32'd0);
    endtask

    task automatic check_restart(input string tag);
        int first;
        first = -1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge CLK48M);
            #1;
            if (vid.PCE === 1'b1) begin
                first = k;
                break;
            end
        end
        check({tag, "_first_pce_cycle"}, 32'(first), 32'd7);
        @(posedge CLK48M);
        #1;
        check({tag, "_first_posh"}, 32'(vid.POSH), 32'd129);
    endtask

    initial begin
        vec_t vecs [5];
        int p0, p1, p2;
        vecs[0] = '{pout: 8'hFF,        red: 8'hFF, grn: 8'hFF, blu: 8'hFF};
        vecs[1] = '{pout: 8'b10_011_101, red: 8'hB6, grn: 8'h6D, blu: 8'hAA};
        vecs[2] = '{pout: 8'h00,        red: 8'h00, grn: 8'h00, blu: 8'h00};
        vecs[3] = '{pout: 8'b01_100_010, red: 8'h49, grn: 8'h92, blu: 8'h55};
        vecs[4] = '{pout: 8'b11_000_111, red: 8'hFF, grn: 8'h00, blu: 8'hFF};

        RESET = 1'b1;
        repeat (4) @(posedge CLK48M);
        #1;
        check_reset_state("rst");
        RESET = 1'b0;
        check_restart("rel");

        // HSYNC: delayed rise after POSH=144, 32 pixels wide
        wait_model_pos(144, -1, 4000, p0);
        wait_sig(1'b0, 1'b1, 200, p1);
        check("hsync_delay", 32'(p1 - p0), 32'(DLY));
        wait_sig(1'b0, 1'b0, 400, p2);
        check("hsync_width", 32'(p2 - p1), 32'd32);

        // Colour table during active video
        rand_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_window(240, 440);
            table_pout = vecs[i].pout;
            repeat (24) @(negedge CLK48M);
            check("tbl_red", 32'(vid.RED), 32'(vecs[i].red));
            check("tbl_grn", 32'(vid.GRN), 32'(vecs[i].grn));
            check("tbl_blu", 32'(vid.BLU), 32'(vecs[i].blu));
        end
        rand_en = 1'b1;

        // VSYNC: starts on line VS_START (delayed), 8 lines wide
        wait_model_pos(128, VS_START, 40000, p0);
        wait_sig(1'b1, 1'b1, 200, p1);
        check("vsync_delay", 32'(p1 - p0), 32'(DLY));
        wait_sig(1'b1, 1'b0, 30000, p2);
        check("vsync_width", 32'(p2 - p1), 32'(8 * 384));

        // One-cycle reset in the middle of a line
        wait_model_pos(300, 12, 8000, p0);
        @(posedge CLK48M);
        #1;
        RESET = 1'b1;
        @(posedge CLK48M);
        #1;
        check_reset_state("midrst");
        RESET = 1'b0;
        check_restart("midrel");

        repeat (2000) @(negedge CLK48M);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
